// File: rtl/bcd_time_chain_pkg.sv
// Shared constants and helpers for the BCD time chain: digit width, per-digit
// modulus extraction and load-value saturation.
package bcd_chain_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] BCD_MOD10 = 4'hA;

    // Modulus of digit i from the packed MODULI word (4'hA reads as mod 10).
    function automatic int digit_mod(input logic [31:0] moduli, input int i);
        return int'(moduli[DIGIT_W*i +: DIGIT_W]);
    endfunction

    // Clamp an out-of-range load digit to the largest legal value.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] val,
                                                     input logic [DIGIT_W-1:0] mod);
        return (val >= mod) ? mod - 4'd1 : val;
    endfunction

endpackage

// File: rtl/bcd_time_chain_if.sv
// Control/status bundle of the BCD time chain. Optional alarm signals exist
// only when BCD_TIME_CHAIN_ALARM_EN is defined.
// Handshake: no valid/ready; ce is a one-cycle tick qualified by load, and
// all status outputs are meaningful every cycle.
interface bcd_time_chain_if #(parameter int NUM_DIGITS = 4);
    import bcd_chain_pkg::*;

    logic                          ce;
    logic                          up_dn;
    logic                          load;
    logic [DIGIT_W*NUM_DIGITS-1:0] load_val;
    logic [DIGIT_W*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]         ceo;
    logic                          tc;
`ifdef BCD_TIME_CHAIN_ALARM_EN
    logic [DIGIT_W*NUM_DIGITS-1:0] alarm_val;
    logic                          alarm;

    modport master (output ce, up_dn, load, load_val, alarm_val,
                    input  digits, ceo, tc, alarm);
    modport slave  (input  ce, up_dn, load, load_val, alarm_val,
                    output digits, ceo, tc, alarm);
`else
    modport master (output ce, up_dn, load, load_val,
                    input  digits, ceo, tc);
    modport slave  (input  ce, up_dn, load, load_val,
                    output digits, ceo, tc);
`endif

endinterface

// File: rtl/bcd_time_chain_digit_stage.sv
// One BCD digit counter with its own modulus: load with saturation, up/down
// advance with wrap, and a combinational terminal-value flag.
module bcd_digit_stage
    import bcd_chain_pkg::*;
#(
    parameter int               MOD     = 10,
    parameter logic [DIGIT_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic               up_dn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    output logic [DIGIT_W-1:0] q,
    output logic               at_term
);

    localparam logic [DIGIT_W-1:0] MOD_V = DIGIT_W'(MOD);
    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= sat_digit(load_d, MOD_V);
        end else if (adv) begin
            if (up_dn) q <= (q == MAX_V) ? '0 : q + 4'd1;
            else       q <= (q == '0) ? MAX_V : q - 4'd1;
        end
    end

    assign at_term = up_dn ? (q == MAX_V) : (q == '0);

endmodule

// File: rtl/bcd_time_chain.sv
// Cascade of BCD digit stages with single-edge carry look-ahead, per-stage
// carry outputs and a registered terminal-count flag.
// Optional alarm compare is built when BCD_TIME_CHAIN_ALARM_EN is defined.
module bcd_time_chain
    import bcd_chain_pkg::*;
#(
    parameter int                            NUM_DIGITS = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] MODULI     = 16'h6A6A,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] RESET_VAL  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_time_chain_if.slave      bus
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    logic [W-1:0]          digits;
    logic [NUM_DIGITS-1:0] at_term;
    logic [NUM_DIGITS:0]   pre;
    logic                  tc_q;

    // pre[i] is the advance for stage i; pre[i+1] is its carry/borrow out.
    // Built as a prefix AND so every qualifying stage updates on one edge.
    always_comb begin
        pre    = '0;
        pre[0] = bus.ce & ~bus.load;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pre[i+1] = pre[i] & at_term[i];
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_stage
        bcd_digit_stage #(
            .MOD     (digit_mod(32'(MODULI), i)),
            .RST_VAL (RESET_VAL[DIGIT_W*i +: DIGIT_W])
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv     (pre[i]),
            .up_dn   (bus.up_dn),
            .load    (bus.load),
            .load_d  (bus.load_val[DIGIT_W*i +: DIGIT_W]),
            .q       (digits[DIGIT_W*i +: DIGIT_W]),
            .at_term (at_term[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tc_q <= 1'b0;
        else       tc_q <= &at_term;
    end

    assign bus.digits = digits;
    assign bus.ceo    = reset ? '0 : pre[NUM_DIGITS:1];
    assign bus.tc     = tc_q;

`ifdef BCD_TIME_CHAIN_ALARM_EN
    logic [W-1:0] prev_digits;
    logic         alarm_q;

    // Fire only on a change into the alarm value, never while parked on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_digits <= RESET_VAL;
            alarm_q     <= 1'b0;
        end else begin
            prev_digits <= digits;
            alarm_q     <= (digits != prev_digits) && (digits == bus.alarm_val);
        end
    end

    assign bus.alarm = alarm_q;
`endif

endmodule
